// File: rtl/config_pkg.sv
// Shared configuration and payload types for the instruction-fetch slice.
package config_pkg;

  localparam int unsigned ENTRY_XLEN = 32;
  localparam int unsigned ENTRY_W    = 2 * ENTRY_XLEN;
  localparam int unsigned FIFO_DEPTH = 2;
  localparam int unsigned CNT_W      = 2;

  typedef struct packed {
    int unsigned           XLEN;
    logic [ENTRY_XLEN-1:0] RESET_PC;
  } config_t;

  localparam config_t DEFAULT_CONF = '{XLEN: ENTRY_XLEN, RESET_PC: ENTRY_XLEN'(32'h8000_0000)};

  typedef enum logic [0:0] {
    FETCH = 1'b0,
    DRAIN = 1'b1
  } fetch_state_t;

  typedef struct packed {
    logic [ENTRY_XLEN-1:0] pc;
    logic [ENTRY_XLEN-1:0] inst;
  } fetch_entry_t;

  // Instruction fetch addresses are always word aligned.
  function automatic logic [ENTRY_XLEN-1:0] word_align(input logic [ENTRY_XLEN-1:0] addr);
    return addr & ~ENTRY_XLEN'(3);
  endfunction

endpackage

// File: rtl/core_fetch_fifo.sv
// Two-entry registered FIFO holding {pc, inst} pairs between memory and decode.
module core_fetch_fifo
  import config_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               push,
  input  logic [ENTRY_W-1:0] push_data,
  input  logic               pop,
  input  logic               flush,
  output logic [CNT_W-1:0]   count,
  output logic [ENTRY_W-1:0] head
);

  fetch_entry_t     slot0_q, slot0_d;
  fetch_entry_t     slot1_q, slot1_d;
  fetch_entry_t     push_entry;
  logic [CNT_W-1:0] count_q, count_d;
  logic             pop_en;
  logic             push_en;

  assign push_entry = fetch_entry_t'(push_data);

  // Slot 0 is always the head; a pop shifts slot 1 down.
  always_comb begin
    slot0_d = slot0_q;
    slot1_d = slot1_q;
    count_d = count_q;
    pop_en  = pop && (count_q != CNT_W'(0));
    push_en = push && ((count_q != CNT_W'(FIFO_DEPTH)) || pop_en);
    if (flush) begin
      count_d = CNT_W'(0);
    end else begin
      if (pop_en) begin
        slot0_d = slot1_q;
      end
      if (push_en) begin
        if ((count_q == CNT_W'(0)) || ((count_q == CNT_W'(1)) && pop_en)) begin
          slot0_d = push_entry;
        end else begin
          slot1_d = push_entry;
        end
      end
      count_d = count_q + CNT_W'(push_en) - CNT_W'(pop_en);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      slot0_q <= '0;
      slot1_q <= '0;
      count_q <= CNT_W'(0);
    end else begin
      slot0_q <= slot0_d;
      slot1_q <= slot1_d;
      count_q <= count_d;
    end
  end

  assign count = count_q;
  assign head  = slot0_q;

endmodule

// File: rtl/core_fetch.sv
// Instruction fetch: issues word requests, buffers in-order responses, and
// squashes stale traffic after a downstream redirect.
module core_fetch
  import config_pkg::*;
#(
  parameter config_t CONF = DEFAULT_CONF,
  localparam int unsigned XLEN = CONF.XLEN
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [XLEN-1:0] imem_rsp_data,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            inst_valid,
  input  logic            inst_ready,
  output logic [XLEN-1:0] inst,
  output logic [XLEN-1:0] inst_pc
);

  localparam int unsigned     SUM_W            = CNT_W + 1;
  localparam logic [XLEN-1:0] PC_STEP          = XLEN'(4);
  localparam logic [XLEN-1:0] RESET_PC_ALIGNED = XLEN'(word_align(CONF.RESET_PC));

  fetch_state_t       state_q, state_d;
  logic [XLEN-1:0]    pc_q, pc_d;
  logic [CNT_W-1:0]   outstanding_q, outstanding_d;
  logic [SUM_W-1:0]   inflight;
  logic               req_fire;
  logic               rsp_live;
  logic               fifo_push;
  logic               fifo_pop;
  logic               fifo_flush;
  logic [CNT_W-1:0]   fifo_count;
  logic [ENTRY_W-1:0] fifo_head_bits;
  fetch_entry_t       push_entry;
  fetch_entry_t       head_entry;
  logic [XLEN-1:0]    rsp_pc;

  // While fetching, outstanding requests are the contiguous words just below pc.
  assign rsp_pc = pc_q - XLEN'({outstanding_q, 2'b00});

  always_comb begin
    state_d        = state_q;
    pc_d           = pc_q;
    outstanding_d  = outstanding_q;
    imem_req_valid = 1'b0;
    fifo_push      = 1'b0;
    fifo_flush     = 1'b0;

    // Only request when the response is guaranteed a FIFO slot.
    inflight = SUM_W'(outstanding_q) + SUM_W'(fifo_count);
    if (!rst && (state_q == FETCH) && (inflight < SUM_W'(FIFO_DEPTH))) begin
      imem_req_valid = 1'b1;
    end

    req_fire      = imem_req_valid && imem_req_ready;
    rsp_live      = imem_rsp_valid && (outstanding_q != CNT_W'(0));
    outstanding_d = outstanding_q + CNT_W'(req_fire) - CNT_W'(rsp_live);
    if (req_fire) begin
      pc_d = pc_q + PC_STEP;
    end

    case (state_q)
      FETCH: fifo_push = rsp_live;
      DRAIN: if (outstanding_d == CNT_W'(0)) state_d = FETCH;
      default: state_d = FETCH;
    endcase

    // A redirect squashes everything, including a request accepted this cycle.
    if (redirect_valid) begin
      pc_d       = redirect_pc & ~XLEN'(3);
      fifo_push  = 1'b0;
      fifo_flush = 1'b1;
      state_d    = (outstanding_d != CNT_W'(0)) ? DRAIN : FETCH;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= FETCH;
      pc_q          <= RESET_PC_ALIGNED;
      outstanding_q <= CNT_W'(0);
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      outstanding_q <= outstanding_d;
    end
  end

  assign push_entry = '{pc: ENTRY_XLEN'(rsp_pc), inst: ENTRY_XLEN'(imem_rsp_data)};
  assign fifo_pop   = inst_valid && inst_ready;

  core_fetch_fifo u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (fifo_push),
    .push_data (push_entry),
    .pop       (fifo_pop),
    .flush     (fifo_flush),
    .count     (fifo_count),
    .head      (fifo_head_bits)
  );

  assign head_entry    = fetch_entry_t'(fifo_head_bits);
  assign imem_req_addr = pc_q;
  assign inst_valid    = (fifo_count != CNT_W'(0));
  assign inst          = XLEN'(head_entry.inst);
  assign inst_pc       = XLEN'(head_entry.pc);

endmodule

// File: doc/core_fetch.md
CORE_FETCH -- requirements
Module: core_fetch

Interface
REQ-001 SHALL take parameter CONF (config_t); CONF.XLEN is the instruction/address width and CONF.RESET_PC is the reset fetch address.
REQ-002 SHALL have ports, in order: clk  in  1  single clock; rst  in  1  synchronous, active-high reset.
REQ-003 SHALL have imem_req_valid  out  1, imem_req_ready  in  1, imem_req_addr  out  XLEN: the instruction-memory request channel.
REQ-004 SHALL have imem_rsp_valid  in  1, imem_rsp_data  in  XLEN: the in-order response channel, latency at least 1 cycle, no backpressure.
REQ-005 SHALL have redirect_valid  in  1, redirect_pc  in  XLEN: the branch/jump redirect from downstream.
REQ-006 SHALL have inst_valid  out  1, inst_ready  in  1, inst  out  XLEN, inst_pc  out  XLEN: the decoder-side stream; inst feeds core_decoder.inst.

Function
REQ-007 SHALL hold fetch PC register pc; a request handshake (imem_req_valid && imem_req_ready) SHALL advance pc by 4, modulo 2^XLEN.
REQ-008 SHALL drive imem_req_addr = pc; bits [1:0] are always zero.
REQ-009 SHALL keep imem_req_valid stable, with addr unchanged, until accepted, unless redirect_valid overrides it.
REQ-010 SHALL track outstanding (0..2, requests accepted but not yet responded to) and fifo_count (0..2).
REQ-011 SHALL assert imem_req_valid only in state FETCH with outstanding + fifo_count < 2, so a response always has a FIFO slot.
REQ-012 SHALL implement FSM FETCH/DRAIN. FETCH: responses are pushed to the FIFO as {pc_of_request, imem_rsp_data}. DRAIN: responses are discarded and no requests are issued.
REQ-013 SHALL handle redirect_valid in any state, as follows:
 - pc <= {redirect_pc[XLEN-1:2], 2'b00};
 - the FIFO is flushed;
 - next state is DRAIN if the post-cycle outstanding is greater than 0, else FETCH.
REQ-014 SHALL transition DRAIN->FETCH in the cycle the last stale response arrives (outstanding becomes 0); the first new request may issue the next cycle.
REQ-015 SHALL count a request accepted in the same cycle as redirect_valid as stale; pc still takes the redirect target.
REQ-016 SHALL drop a response arriving in the same cycle as redirect_valid.
REQ-017 SHALL treat an inst handshake in the same cycle as redirect_valid as consumed; the remaining entries are flushed.
REQ-018 SHALL present a response arriving in cycle N on inst_valid at N+1 (registered FIFO, no bypass); total fetch latency = memory latency + 1.
REQ-019 SHALL allow a FIFO push and pop in the same cycle when full, with count unchanged.
REQ-020 SHALL ignore imem_rsp_valid while outstanding == 0; no state changes.
REQ-021 SHALL keep inst/inst_pc stable while inst_valid && !inst_ready.

Reset
REQ-022 SHALL on rst produce the following state:
 - pc = CONF.RESET_PC with bits [1:0] cleared;
 - state = FETCH;
 - outstanding = 0;
 - FIFO empty.
REQ-023 SHALL hold the following outputs at reset: imem_req_valid = 0, inst_valid = 0, imem_req_addr = RESET_PC, inst = 0, inst_pc = 0.
REQ-024 SHALL issue the first request in the first cycle after rst deasserts.
REQ-025 SHALL discard, after a mid-operation reset, responses to requests issued before reset; the memory is reset in the same cycle.

Structure
REQ-026 SHALL take RESET_PC as a field of config_t in config_pkg.
REQ-027 SHALL define fetch_state_t (FETCH, DRAIN) and fetch_entry_t {pc, inst} in config_pkg.
REQ-028 SHALL place the 2-entry FIFO in sub-module core_fetch_fifo with push/pop/flush, count and head outputs, and synchronous active-high rst.

Verification
REQ-029 Reset vector: RESET_PC=0x80000000, rst high 2 cycles, ready=1, 1-cycle memory -> first addr 0x80000000, then 0x80000004; inst_valid one cycle after each response.
REQ-030 Backpressure: inst_ready=0 for 10 cycles -> at most 2 requests in flight+buffered, no lost or duplicated inst; release yields pc order 0x..00, 0x..04, 0x..08.
REQ-031 Redirect with 2 outstanding, 3-cycle memory: redirect_pc=0x80000103 -> both stale responses dropped; next request addr 0x80000100 issues only after outstanding==0.
REQ-032 Simultaneous events: redirect, request accept and inst handshake in one cycle -> accepted request treated as stale, handshaken inst delivered, FIFO empty next cycle.
REQ-033 Wrap: redirect_pc=0xFFFFFFFC -> requests 0xFFFFFFFC then 0x00000000.
REQ-034 Reset mid-DRAIN: rst asserted with outstanding=2 -> next cycle state FETCH, outputs at reset values; request at RESET_PC follows.
